branch_ctrl: RTL
================

# branch_ctrl

Branch-prediction and PC-sequencing controller for the picoMIPS pipeline. It sits beside the program counter and drives the counter's control inputs (`take_branch`, `predicted_target`, `mispredict`, `reg_pc_plus`, `show`). It holds a small direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It tracks each fetched instruction's prediction through ID to EX, resolves it against the EX outcome, and issues recovery and flush requests.

## Interface
Parameters:
- `Psize`, default 5: PC width (up to 32 instructions).
- `Bsize`, default 2: BTB index bits; the BTB has 2^Bsize entries.

Ports:
- `clk`  in  1  clock.
- `nreset`  in  1  asynchronous, active-low reset.
- `fetch_pc`  in  Psize  current PC, taken from the PC block's `pc` output.
- `stall_req`  in  1  load-use hazard from decode; requests a one-instruction replay.
- `ex_is_branch`  in  1  the instruction in EX is a branch.
- `ex_taken`  in  1  the branch in EX resolved as taken.
- `ex_target`  in  Psize  resolved target of the branch in EX.
- `take_branch`  out  1  redirect the PC to `predicted_target` at the next edge.
- `predicted_target`  out  Psize  BTB target for `fetch_pc`.
- `mispredict`  out  1  load the PC from `reg_pc_plus` at the next edge.
- `reg_pc_plus`  out  Psize  correct recovery address.
- `show`  out  1  rewind the PC by one (replay).
- `flush`  out  1  squash the IF/ID and ID/EX pipeline registers.
- `br_count`  out  8  resolved branches; saturates at 255.
- `mp_count`  out  8  mispredicts; saturates at 255.

## Operation
BTB entry fields:
- `valid`.
- `tag`, equal to `fetch_pc[Psize-1:Bsize]`.
- `target`, Psize bits.
- `ctr`, 2 bits.
- Index is `fetch_pc[Bsize-1:0]`.

Prediction (combinational):
- `hit` = `valid` & tag match.
- `pred_taken` = `hit` & `ctr[1]`.
- `predicted_target` = entry `target` when `hit`, otherwise 0.

Tracking pipeline:
- Two metadata stages, ID and EX. Each stage holds {`v`, `pc`, `pred_taken`, `pred_target`}.
- Each cycle, IF metadata moves to ID and ID moves to EX.

Resolution (EX stage, when `v` = 1):
- `mispredict` when any of the following holds:
  - `ex_is_branch` & (`ex_taken` != `pred_taken`);
  - `ex_is_branch` & `ex_taken` & `pred_taken` & (`ex_target` != `pred_target`);
  - !`ex_is_branch` & `pred_taken`.
- `reg_pc_plus` = `ex_target` when `ex_is_branch` & `ex_taken`, otherwise EX `pc`+1 (mod 2^Psize).
- `reg_pc_plus` is driven continuously from EX metadata; it is 0 when EX `v` = 0.

BTB update (registered at the clock edge, for an EX instruction with `v` = 1):
- Branch hit: `ctr` increments toward 11 if taken, decrements toward 00 if not taken; `target` is set to `ex_target` if taken.
- Branch miss, taken: allocate the entry with `valid` = 1, new tag, `target` = `ex_target`, `ctr` = 10.
- Branch miss, not taken: no change.
- Non-branch that was predicted taken: clear `valid`.

Priority: `mispredict` > `stall_req` > prediction.
- `take_branch` = `pred_taken` & !`stall_req` & !`mispredict`.
- `show` = `stall_req` & !`mispredict`.
- `flush` = `mispredict`.
- On mispredict: both metadata stages load `v` = 0 at the edge.
- On stall: ID holds its contents, EX loads a bubble (`v` = 0).

Counters:
- `br_count` increments on each resolved branch (EX `v` & `ex_is_branch`).
- `mp_count` increments on each mispredict.

## Timing
- Prediction is zero-latency: `take_branch` and `predicted_target` are combinational on `fetch_pc`, and the PC redirects at the next edge.
- Resolution is 2 cycles after fetch; `mispredict` is combinational in the EX cycle, and the PC recovers at the following edge.
- BTB writes take effect at the edge. A same-cycle lookup of the index being written sees the old contents.
- Reset state:
  - All BTB entries invalid with `ctr` = 01.
  - Metadata `v` = 0; `br_count` = `mp_count` = 0.
  - All outputs are 0, because `pred_taken` = 0 and EX `v` = 0.
- Reset asserted mid-operation clears all of the above immediately (asynchronous).
- PC arithmetic wraps modulo 2^Psize: with `Psize` = 5, a not-taken branch at PC 31 gives `reg_pc_plus` = 0.

## Test plan
All scenarios use `Psize` = 5, `Bsize` = 2.

1. Reset, then sweep `fetch_pc` 0..31 → `take_branch` = 0 and `predicted_target` = 0 throughout; `mispredict` = `show` = `flush` = 0.
2. Cold branch at PC 6 with `ex_taken` = 1, `ex_target` = 2, seen in EX → `mispredict` = `flush` = 1, `reg_pc_plus` = 2, `mp_count` = 1. A later fetch of PC 6 → `take_branch` = 1, `predicted_target` = 2.
3. Loop back at PC 6 → 2, taken again, with a correct prediction → `mispredict` = 0, `ctr` 10 → 11, `br_count` increments. Then a not-taken exit → `mispredict` = 1, `reg_pc_plus` = 7, `ctr` = 10.
4. Aliasing, with PC 6 allocated:
   - Fetch PC 14 (same index, different tag) → no hit, `take_branch` = 0.
   - A non-branch at PC 6 predicted taken → `mispredict` = 1, `reg_pc_plus` = 7, and the entry is invalidated.
5. `stall_req` = 1 while `fetch_pc` hits → `show` = 1, `take_branch` = 0, ID metadata held, EX bubble. `stall_req` in the same cycle as a `mispredict` → `show` = 0, `mispredict` = 1, both stages squashed.
6. Not-taken branch at PC 31 → `reg_pc_plus` = 0. 300 mispredicts → `mp_count` saturates at 255. `nreset` pulsed mid-loop → outputs and counters return to 0 immediately.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// Groups the PC-sequencing handshake between the PC block, decode/EX and branch_ctrl.
// Latency: none; this is only wiring.
// Backpressure: stall_req (replay) and mispredict (flush) are the only throttles carried here.
interface branch_ctrl_if #(
    parameter int Psize = 5
);
    // Fetch side: current PC and the hazard replay request from decode
    logic [Psize-1:0] fetch_pc;
    logic             stall_req;

    // Resolution side: outcome of the instruction sitting in EX
    logic             ex_is_branch;
    logic             ex_taken;
    logic [Psize-1:0] ex_target;

    // PC control outputs
    logic             take_branch;
    logic [Psize-1:0] predicted_target;
    logic             mispredict;
    logic [Psize-1:0] reg_pc_plus;
    logic             show;
    logic             flush;

    // Statistics
    logic [7:0]       br_count;
    logic [7:0]       mp_count;

    // The pipeline/testbench side drives PC and EX information and observes the controls
    modport master (
        output fetch_pc, stall_req, ex_is_branch, ex_taken, ex_target,
        input  take_branch, predicted_target, mispredict, reg_pc_plus, show, flush,
               br_count, mp_count
    );

    // The branch controller consumes PC and EX information and drives the controls
    modport slave (
        input  fetch_pc, stall_req, ex_is_branch, ex_taken, ex_target,
        output take_branch, predicted_target, mispredict, reg_pc_plus, show, flush,
               br_count, mp_count
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch predictor and PC sequencer: direct-mapped BTB with 2-bit counters, ID/EX tracking, recovery.
// Latency: prediction is combinational on fetch_pc; resolution is combinational in EX, 2 cycles after fetch.
// Backpressure: mispredict squashes ID/EX; stall_req holds ID and bubbles EX; mispredict wins over stall.
module branch_ctrl #(
    parameter int Psize = 5,
    parameter int Bsize = 2
) (
    input  logic         clk,
    input  logic         nreset,
    branch_ctrl_if.slave bus
);

    localparam int NENT = 1 << Bsize;
    localparam int TW   = Psize - Bsize;

    // One BTB line: the tag is the PC bits above the index
    typedef struct packed {
        logic             valid;
        logic [TW-1:0]    tag;
        logic [Psize-1:0] target;
        logic [1:0]       ctr;
    } btb_entry_t;

    // Prediction record that travels alongside an instruction through ID and EX
    typedef struct packed {
        logic             v;
        logic [Psize-1:0] pc;
        logic             pred_taken;
        logic [Psize-1:0] pred_target;
    } meta_t;

    btb_entry_t btb_q [NENT];
    btb_entry_t btb_d [NENT];

    meta_t if_meta;
    meta_t id_q, id_d;
    meta_t ex_q, ex_d;

    logic [7:0] br_count_q, br_count_d;
    logic [7:0] mp_count_q, mp_count_d;

    // Fetch-side lookup signals
    logic [Bsize-1:0] f_idx;
    logic [TW-1:0]    f_tag;
    logic             f_hit;
    logic             f_pred_taken;
    logic [Psize-1:0] f_pred_target;

    // EX-side resolution signals
    logic [Bsize-1:0] e_idx;
    logic [TW-1:0]    e_tag;
    logic             e_hit;
    logic [1:0]       e_ctr;
    logic             ex_mp;
    logic             ex_resolved_br;
    logic [Psize-1:0] ex_pc_inc;
    logic [Psize-1:0] ex_recover_pc;

    // Look up the current fetch PC; a miss predicts not-taken with a zero target
    always_comb begin
        f_idx         = bus.fetch_pc[Bsize-1:0];
        f_tag         = bus.fetch_pc[Psize-1:Bsize];
        f_hit         = btb_q[f_idx].valid && (btb_q[f_idx].tag == f_tag);
        f_pred_taken  = f_hit && btb_q[f_idx].ctr[1];
        f_pred_target = f_hit ? btb_q[f_idx].target : '0;

        if_meta.v           = 1'b1;
        if_meta.pc          = bus.fetch_pc;
        if_meta.pred_taken  = f_pred_taken;
        if_meta.pred_target = f_pred_target;
    end

    // Resolve the EX instruction against its prediction and pick the recovery address
    always_comb begin
        e_idx = ex_q.pc[Bsize-1:0];
        e_tag = ex_q.pc[Psize-1:Bsize];
        e_hit = btb_q[e_idx].valid && (btb_q[e_idx].tag == e_tag);
        e_ctr = btb_q[e_idx].ctr;

        ex_mp = 1'b0;
        if (ex_q.v) begin
            if (bus.ex_is_branch) begin
                // Wrong direction, or right direction but stale target
                ex_mp = (bus.ex_taken != ex_q.pred_taken) ||
                        (bus.ex_taken && ex_q.pred_taken && (bus.ex_target != ex_q.pred_target));
            end else begin
                // A non-branch that redirected fetch must be undone
                ex_mp = ex_q.pred_taken;
            end
        end

        ex_resolved_br = ex_q.v && bus.ex_is_branch;

        // PC arithmetic wraps naturally at Psize bits
        ex_pc_inc = ex_q.pc + {{(Psize-1){1'b0}}, 1'b1};

        ex_recover_pc = '0;
        if (ex_q.v) begin
            if (bus.ex_is_branch && bus.ex_taken) begin
                ex_recover_pc = bus.ex_target;
            end else begin
                ex_recover_pc = ex_pc_inc;
            end
        end
    end

    // BTB training from the EX outcome; writes land at the edge so same-cycle reads see old data
    always_comb begin
        btb_d = btb_q;
        if (ex_q.v) begin
            if (bus.ex_is_branch) begin
                if (e_hit) begin
                    if (bus.ex_taken) begin
                        if (e_ctr != 2'b11) begin
                            btb_d[e_idx].ctr = e_ctr + 2'd1;
                        end
                        btb_d[e_idx].target = bus.ex_target;
                    end else if (e_ctr != 2'b00) begin
                        btb_d[e_idx].ctr = e_ctr - 2'd1;
                    end
                end else if (bus.ex_taken) begin
                    // Cold taken branch: allocate weakly-taken
                    btb_d[e_idx].valid  = 1'b1;
                    btb_d[e_idx].tag    = e_tag;
                    btb_d[e_idx].target = bus.ex_target;
                    btb_d[e_idx].ctr    = 2'b10;
                end
            end else if (ex_q.pred_taken) begin
                // Entry aliased onto a non-branch: drop it
                btb_d[e_idx].valid = 1'b0;
            end
        end
    end

    // BTB storage; reset leaves every line invalid and weakly not-taken
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NENT; i++) begin
                btb_q[i].valid  <= 1'b0;
                btb_q[i].tag    <= '0;
                btb_q[i].target <= '0;
                btb_q[i].ctr    <= 2'b01;
            end
        end else begin
            btb_q <= btb_d;
        end
    end

    // Metadata advance: mispredict squashes both stages, stall holds ID and bubbles EX
    always_comb begin
        id_d = id_q;
        ex_d = ex_q;
        if (ex_mp) begin
            id_d = '0;
            ex_d = '0;
        end else if (bus.stall_req) begin
            ex_d = '0;
        end else begin
            id_d = if_meta;
            ex_d = id_q;
        end
    end

    // Metadata stage registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            id_q <= '0;
            ex_q <= '0;
        end else begin
            id_q <= id_d;
            ex_q <= ex_d;
        end
    end

    // Saturating statistics counters
    always_comb begin
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (ex_resolved_br && (br_count_q != 8'hFF)) begin
            br_count_d = br_count_q + 8'd1;
        end
        if (ex_mp && (mp_count_q != 8'hFF)) begin
            mp_count_d = mp_count_q + 8'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    // Priority: mispredict over stall over prediction
    assign bus.take_branch      = f_pred_taken && !bus.stall_req && !ex_mp;
    assign bus.predicted_target = f_pred_target;
    assign bus.mispredict       = ex_mp;
    assign bus.reg_pc_plus      = ex_recover_pc;
    assign bus.show             = bus.stall_req && !ex_mp;
    assign bus.flush            = ex_mp;
    assign bus.br_count         = br_count_q;
    assign bus.mp_count         = mp_count_q;

endmodule
